inst_fetch_queue: RTL and testbench

Instruction fetch front-end for the KLP32 core. It owns the fetch PC, issues in-order read requests to a handshaked instruction memory, and buffers returned words in a small FIFO. It presents one instruction per cycle with its PC to the decode/execute stage, and flushes on a taken-branch/jump redirect, replacing the combinational PC → instruction-memory path.

---
 rtl/inst_fetch_queue_if.sv | 40 ++++
 rtl/inst_fetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
//   Bundles the fetch front-end signals: the redirect input from execute, the
//   request/response channels to instruction memory, and the instruction
//   handshake to decode/execute.
//   master : the fetch queue itself (drives requests and the instruction head)
//   slave  : the environment (memory, execute redirect, decode consumer)
//
//   redirect / redirect_pc          taken branch/jump and its target
//   imem_req_valid/addr/ready       in-order fetch request handshake
//   imem_rsp_valid/data             in-order returned words
//   inst_valid/inst/inst_pc/...     queue head presented to decode
//   inst_ready                      consumer takes the head this cycle
interface inst_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        inst_ready;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               inst_pc_plus4
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               inst_pc_plus4
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front-end: owns the fetch PC, issues in-order requests
//   to instruction memory under a credit limit of DEPTH (FIFO entries plus
//   requests in flight), buffers returned words with their PCs, and flushes
//   on a redirect. Words still in flight at a redirect are counted in a drop
//   counter and discarded when they return.
//
//   Parameters: DEPTH (power of two, >= 2), RESET_PC.
//   Ports: clk, reset (async, active-high), bus (inst_fetch_queue_if.master).
//
//   Optional macro IFQ_BYPASS_EN: when the FIFO is empty and nothing is being
//   dropped or redirected, a returning word is presented combinationally on
//   the instruction head (zero latency); it is enqueued only if not consumed.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_word_mem [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_req_valid;
    logic          w_accept;
    logic [31:0]   w_rsp_pc;
    logic          w_fifo_empty;
    logic          w_rsp_keep;
    logic          w_byp;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_out_next;
    logic          w_unused;

    assign w_unused = ^bus.redirect_pc[1:0];

    assign w_credit_used = {1'b0, r_cnt} + {1'b0, r_out};
    assign w_req_valid   = !reset && (w_credit_used < DEPTH_W);
    assign w_accept      = w_req_valid && bus.imem_req_ready;

    // Responses return in order, so the oldest outstanding request was issued
    // r_out words behind the current fetch PC. Once drop reaches zero every
    // outstanding request post-dates the last redirect, so this PC is exact.
    assign w_rsp_pc      = r_fetch_pc - {{(30 - CW){1'b0}}, r_out, 2'b00};

    assign w_fifo_empty  = (r_cnt == '0);
    assign w_rsp_keep    = bus.imem_rsp_valid && (r_drop == '0) && !bus.redirect;

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_fifo_empty && w_rsp_keep && !reset;
`else
    assign w_byp = 1'b0;
`endif

    assign w_pop      = !w_fifo_empty && bus.inst_ready;
    assign w_push     = w_rsp_keep && !(w_byp && bus.inst_ready);
    assign w_out_next = r_out + CW'(w_accept) - CW'(bus.imem_rsp_valid);

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;

    // Empty head is forced to zero so stale RAM contents never show.
    always_comb begin
        bus.inst_valid = !w_fifo_empty || w_byp;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (w_byp) begin
            bus.inst    = bus.imem_rsp_data;
            bus.inst_pc = w_rsp_pc;
        end else if (!w_fifo_empty) begin
            bus.inst    = r_word_mem[r_rd_ptr];
            bus.inst_pc = r_pc_mem[r_rd_ptr];
        end
        bus.inst_pc_plus4 = bus.inst_pc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_cnt      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_out <= w_out_next;
            if (bus.redirect) begin
                // Everything still in flight after this cycle, including a
                // request accepted right now, belongs to the old path.
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_cnt      <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop     <= w_out_next;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
                if (bus.imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= w_rsp_pc;
            r_word_mem[r_wr_ptr] <= bus.imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_cnt == DEPTH_W[CW-1:0])));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        int          lat;
        int          pre;
        logic        rdy_redir;
        int          mode_after;
        logic [31:0] exp_addr;
    } vec_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] cons_log[$];
    logic [31:0] exp_req;
    int          cyc = 0;
    int          lat = 1;
    int          rdy_mode = 0;
    logic        ir = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_cons = 0;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, sample #1 later.
    task automatic step(input logic rd, input logic [31:0] rpc);
        exp_t  e;
        mreq_t m;
        @(negedge clk);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = ir;
        bus.imem_req_ready = (rdy_mode == 0) ? 1'b1 :
                             (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        s_req_valid  = bus.imem_req_valid;
        s_req_addr   = bus.imem_req_addr;
        s_inst_valid = bus.inst_valid;
        if (bus.inst_valid && bus.inst_ready) begin
            n_cons++;
            cons_log.push_back(bus.inst_pc);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h expected no instruction", bus.inst_pc);
            end else begin
                e = sb.pop_front();
                chk("inst_pc", bus.inst_pc, e.pc);
                chk("inst", bus.inst, e.word);
                chk("inst_pc_plus4", bus.inst_pc_plus4, e.pc + 32'd4);
            end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_req);
            n_acc++;
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            sb.push_back('{pc: exp_req, word: mem_word(exp_req)});
            exp_req = exp_req + 32'd4;
        end
        if (rd) begin
            sb.delete();
            exp_req = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        mq.delete();
        sb.delete();
        cons_log.delete();
        exp_req = RST_PC;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_pc_plus4", bus.inst_pc_plus4, 32'd4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", bus.imem_req_addr, RST_PC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int   m;
        vt[0] = '{rpc: 32'h0000_0100, lat: 4, pre: 3, rdy_redir: 1'b0, mode_after: 0, exp_addr: 32'h0000_0100};
        vt[1] = '{rpc: 32'h0000_0203, lat: 2, pre: 2, rdy_redir: 1'b1, mode_after: 0, exp_addr: 32'h0000_0200};
        vt[2] = '{rpc: 32'hFFFF_FFF8, lat: 3, pre: 1, rdy_redir: 1'b1, mode_after: 1, exp_addr: 32'hFFFF_FFF8};
        vt[3] = '{rpc: 32'h0000_1003, lat: 1, pre: 2, rdy_redir: 1'b1, mode_after: 0, exp_addr: 32'h0000_1000};

        idle_inputs();
        exp_req = RST_PC;

        // Latency 1, consumer always ready: full throughput from RESET_PC.
        do_reset();
        lat = 1; rdy_mode = 0; ir = 1'b1;
        repeat (5) step(1'b0, '0);
        m = n_cons;
        repeat (20) step(1'b0, '0);
        chk("throughput", 32'(n_cons - m), 32'd20);
        if (cons_log.size() >= 3) begin
            chk("seq_pc0", cons_log[0], 32'h0);
            chk("seq_pc1", cons_log[1], 32'h4);
            chk("seq_pc2", cons_log[2], 32'h8);
        end else begin
            chk("seq_count", 32'(cons_log.size()), 32'd3);
        end

        // Back-pressure: exactly DEPTH requests, then nothing lost.
        do_reset();
        lat = 2; rdy_mode = 0; ir = 1'b0;
        m = n_acc;
        repeat (10) step(1'b0, '0);
        chk("bp_accepts", 32'(n_acc - m), 32'd4);
        chk("bp_req_valid", 32'(s_req_valid), 32'd0);
        chk("bp_inst_valid", 32'(s_inst_valid), 32'd1);
        ir = 1'b1;
        repeat (20) step(1'b0, '0);
        if (cons_log.size() >= 4) begin
            for (int unsigned i = 0; i < 4; i++) begin
                chk("bp_pc", cons_log[i], 32'(i * 4));
            end
        end else begin
            chk("bp_count", 32'(cons_log.size()), 32'd4);
        end

        // Redirect vectors.
        for (int unsigned i = 0; i < 4; i++) begin
            do_reset();
            lat = vt[i].lat; rdy_mode = 0; ir = 1'b1;
            repeat (vt[i].pre) step(1'b0, '0);
            rdy_mode = vt[i].rdy_redir ? 0 : 2;
            step(1'b1, vt[i].rpc);
            rdy_mode = vt[i].mode_after;
            cons_log.delete();
            step(1'b0, '0);
            chk("redir_inst_valid_n1", 32'(s_inst_valid), 32'd0);
            chk("redir_req_valid_n1", 32'(s_req_valid), 32'd1);
            chk("redir_req_addr_n1", s_req_addr, vt[i].exp_addr);
            repeat (60) step(1'b0, '0);
            if (cons_log.size() >= 3) begin
                chk("redir_pc0", cons_log[0], vt[i].exp_addr);
                chk("redir_pc1", cons_log[1], vt[i].exp_addr + 32'd4);
                chk("redir_pc2", cons_log[2], vt[i].exp_addr + 32'd8);
            end else begin
                chk("redir_count", 32'(cons_log.size()), 32'd3);
            end
        end

        // Reset with two entries queued and one request in flight.
        do_reset();
        lat = 2; rdy_mode = 0; ir = 1'b0;
        repeat (3) step(1'b0, '0);
        rdy_mode = 2;
        step(1'b0, '0);
        chk("mid_inst_valid_before", 32'(s_inst_valid), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        mq.delete();
        sb.delete();
        #1;
        chk("async_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        do_reset();
        lat = 1; rdy_mode = 0; ir = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("first_rsp_inst_valid", 32'(s_inst_valid), 32'(BYP));
        repeat (5) step(1'b0, '0);
        if (cons_log.size() >= 1) begin
            chk("restart_pc", cons_log[0], RST_PC);
        end else begin
            chk("restart_count", 32'(cons_log.size()), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
